// File: rtl/sequentializer_pkg.sv
// Shared FSM state type and geometry helpers for the center-out line/stripe scheduler.
package sequentializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    function automatic int unsigned num_stripes(input int unsigned cols, input int unsigned ppb);
        return cols / ppb;
    endfunction

    function automatic int unsigned center_index(input int unsigned n);
        return n / 2;
    endfunction

endpackage

// File: rtl/center_out_counter.sv
// Walks 0..N-1 center-out in groups of GROUP: lower group ascending, then upper group ascending.
module center_out_counter
    import sequentializer_pkg::*;
#(
    parameter int unsigned N     = 104,
    parameter int unsigned GROUP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step,
    input  logic                 clear,
    output logic [$clog2(N)-1:0] index,
    output logic                 last
);

    localparam int unsigned IW    = $clog2(N);
    localparam int unsigned C     = center_index(N);
    localparam int unsigned NPAIR = N / (2 * GROUP);
    localparam int unsigned KW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int unsigned OW    = (GROUP > 1) ? $clog2(GROUP) : 1;

    logic [KW-1:0] k_q, k_d;
    logic          half_q, half_d;
    logic [OW-1:0] off_q, off_d;
    logic [IW-1:0] lo_q, lo_d;
    logic [IW-1:0] hi_q, hi_d;
    logic [IW-1:0] index_q, index_d;
    logic          last_q, last_d;

    // Group bases move by GROUP per pair so no multiply is needed.
    always_comb begin
        k_d    = k_q;
        half_d = half_q;
        off_d  = off_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        if (clear) begin
            k_d    = '0;
            half_d = 1'b0;
            off_d  = '0;
            lo_d   = IW'(C - GROUP);
            hi_d   = IW'(C);
        end else if (step) begin
            if (off_q == OW'(GROUP - 1)) begin
                off_d  = '0;
                half_d = !half_q;
                if (half_q) begin
                    if (k_q == KW'(NPAIR - 1)) begin
                        k_d  = '0;
                        lo_d = IW'(C - GROUP);
                        hi_d = IW'(C);
                    end else begin
                        k_d  = k_q + 1'b1;
                        lo_d = lo_q - IW'(GROUP);
                        hi_d = hi_q + IW'(GROUP);
                    end
                end
            end else begin
                off_d = off_q + 1'b1;
            end
        end
        index_d = (half_d ? hi_d : lo_d) + IW'(off_d);
        last_d  = half_d && (k_d == KW'(NPAIR - 1)) && (off_d == OW'(GROUP - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            half_q  <= 1'b0;
            off_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
        end else begin
            k_q     <= k_d;
            half_q  <= half_d;
            off_q   <= off_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            index_q <= index_d;
            last_q  <= last_d;
        end
    end

    assign index = index_q;
    assign last  = last_q;

endmodule

// File: rtl/line_order_scheduler.sv
// Issues one (row, stripe) burst command per handshake, lines and stripes both center-out.
module line_order_scheduler
    import sequentializer_pkg::*;
#(
    parameter int unsigned IN_ROWS          = 104,
    parameter int unsigned IN_COLS          = 416,
    parameter int unsigned PIXELS_PER_BURST = 16,
    parameter int unsigned LINE_GROUP       = 4
) (
    input  logic                                          clk,
    input  logic                                          s_axis_resetn,
    input  logic                                          frame_start,
    output logic                                          m_cmd_tvalid,
    input  logic                                          m_cmd_tready,
    output logic [$clog2(IN_ROWS)-1:0]                    m_cmd_row,
    output logic [$clog2(IN_COLS/PIXELS_PER_BURST)-1:0]   m_cmd_stripe,
    output logic                                          m_cmd_last_line,
    output logic                                          m_cmd_last_frame,
    output logic                                          busy,
    output logic                                          frame_done,
    output logic                                          overrun
);

    localparam int unsigned NUM_STRIPES = num_stripes(IN_COLS, PIXELS_PER_BURST);

    state_e state_q, state_d;
    logic   valid_q, valid_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   overrun_q, overrun_d;

    logic hs, last_hs;
    logic ctr_clear, stripe_step, line_step;
    logic stripe_last, line_last;

    assign hs      = valid_q & m_cmd_tready;
    assign last_hs = hs & stripe_last & line_last;

    // frame_start always restarts; coincident with the last handshake it is a clean new frame.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        overrun_d   = 1'b0;
        ctr_clear   = 1'b0;
        stripe_step = 1'b0;
        line_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d   = ST_ISSUE;
                    ctr_clear = 1'b1;
                end
            end
            ST_ISSUE: begin
                done_d = last_hs;
                if (frame_start) begin
                    ctr_clear = 1'b1;
                    overrun_d = !last_hs;
                end else if (hs) begin
                    stripe_step = 1'b1;
                    line_step   = stripe_last;
                    if (last_hs) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_ISSUE);
        busy_d  = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    center_out_counter #(
        .N     (NUM_STRIPES),
        .GROUP (1)
    ) u_stripe_ctr (
        .clk   (clk),
        .rst_n (s_axis_resetn),
        .step  (stripe_step),
        .clear (ctr_clear),
        .index (m_cmd_stripe),
        .last  (stripe_last)
    );

    center_out_counter #(
        .N     (IN_ROWS),
        .GROUP (LINE_GROUP)
    ) u_line_ctr (
        .clk   (clk),
        .rst_n (s_axis_resetn),
        .step  (line_step),
        .clear (ctr_clear),
        .index (m_cmd_row),
        .last  (line_last)
    );

    assign m_cmd_tvalid     = valid_q;
    assign busy             = busy_q;
    assign frame_done       = done_q;
    assign overrun          = overrun_q;
    assign m_cmd_last_line  = stripe_last;
    assign m_cmd_last_frame = stripe_last & line_last;

endmodule

// File: tb/tb_line_order_scheduler.sv
// Scoreboard bench: stimulus queues expected commands/status, a negedge monitor checks them.
module tb_line_order_scheduler;

    localparam int ROWS = 104;
    localparam int NS   = 26;
    localparam int G    = 4;
    localparam int C    = 52;
    localparam int CS   = 13;
    localparam int RW   = 7;
    localparam int SW   = 5;

    logic          clk = 1'b0;
    logic          s_axis_resetn;
    logic          frame_start;
    logic          m_cmd_tvalid;
    logic          m_cmd_tready;
    logic [RW-1:0] m_cmd_row;
    logic [SW-1:0] m_cmd_stripe;
    logic          m_cmd_last_line;
    logic          m_cmd_last_frame;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    line_order_scheduler #(
        .IN_ROWS          (104),
        .IN_COLS          (416),
        .PIXELS_PER_BURST (16),
        .LINE_GROUP       (4)
    ) dut (
        .clk              (clk),
        .s_axis_resetn    (s_axis_resetn),
        .frame_start      (frame_start),
        .m_cmd_tvalid     (m_cmd_tvalid),
        .m_cmd_tready     (m_cmd_tready),
        .m_cmd_row        (m_cmd_row),
        .m_cmd_stripe     (m_cmd_stripe),
        .m_cmd_last_line  (m_cmd_last_line),
        .m_cmd_last_frame (m_cmd_last_frame),
        .busy             (busy),
        .frame_done       (frame_done),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int row;
        int stripe;
        bit ll;
        bit lf;
    } exp_t;

    typedef struct {
        int    cyc;
        string name;
        bit    valid;
        bit    bsy;
        bit    done;
        bit    ovr;
        bit    chk_cmd;
        int    row;
        int    stripe;
        bit    ll;
        bit    lf;
    } st_t;

    exp_t exp_q[$];
    st_t  st_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int stall_cnt = 0;
    bit end_req  = 1'b0;
    bit end_done = 1'b0;

    // Hand-computed points of the default frame: (command index, row, stripe, last_line, last_frame)
    int tbl_idx[8] = '{0, 1, 2, 25, 26, 104, 208, 2703};
    int tbl_row[8] = '{48, 48, 48, 48, 49, 52, 44, 103};
    int tbl_str[8] = '{12, 13, 11, 25, 12, 12, 12, 25};
    bit tbl_ll[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit tbl_lf[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};

    task automatic push_frame();
        exp_t e;
        for (int li = 0; li < ROWS; li++) begin
            int k;
            int r;
            int row;
            k   = li / (2 * G);
            r   = li % (2 * G);
            row = (r < G) ? (C - G * (k + 1) + r) : (C + G * k + (r - G));
            for (int si = 0; si < NS; si++) begin
                e.idx    = li * NS + si;
                e.row    = row;
                e.stripe = (si % 2 == 0) ? (CS - 1 - si / 2) : (CS + si / 2);
                e.ll     = (si == NS - 1);
                e.lf     = (si == NS - 1) && (li == ROWS - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic expect_status(input int off, input string name, input bit v, input bit b,
                                 input bit d, input bit o, input bit cc, input int row,
                                 input int stripe, input bit ll, input bit lf);
        st_t s;
        s.cyc = cyc + off; s.name = name; s.valid = v; s.bsy = b; s.done = d; s.ovr = o;
        s.chk_cmd = cc; s.row = row; s.stripe = stripe; s.ll = ll; s.lf = lf;
        st_q.push_back(s);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        push_frame();
        expect_status(1, "pre_start", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_status(2, "first_cmd", 1, 1, 0, 0, 1, 48, 12, 0, 0);
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic run_until_empty(input bit random_ready);
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
            if (random_ready) m_cmd_tready = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: compares every valid cycle against the queue head, pops on handshake.
    always @(negedge clk) begin
        exp_t e;
        st_t  s;
        bit   matched;
        bit   popped;
        cyc     = cyc + 1;
        matched = 1'b0;
        popped  = 1'b0;
        if (m_cmd_tvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cmd: got row=%0d stripe=%0d with no command expected",
                         m_cmd_row, m_cmd_stripe);
            end else begin
                e = exp_q[0];
                if (m_cmd_row !== RW'(e.row) || m_cmd_stripe !== SW'(e.stripe) ||
                    m_cmd_last_line !== e.ll || m_cmd_last_frame !== e.lf) begin
                    errors++;
                    $display("FAIL cmd_%0d: got row=%0d stripe=%0d ll=%0b lf=%0b want row=%0d stripe=%0d ll=%0b lf=%0b",
                             e.idx, m_cmd_row, m_cmd_stripe, m_cmd_last_line, m_cmd_last_frame,
                             e.row, e.stripe, e.ll, e.lf);
                end
                for (int t = 0; t < 8; t++) begin
                    if (e.idx == tbl_idx[t]) begin
                        checks++;
                        if (m_cmd_row !== RW'(tbl_row[t]) || m_cmd_stripe !== SW'(tbl_str[t]) ||
                            m_cmd_last_line !== tbl_ll[t] || m_cmd_last_frame !== tbl_lf[t]) begin
                            errors++;
                            $display("FAIL directed_%0d: got row=%0d stripe=%0d ll=%0b lf=%0b want row=%0d stripe=%0d ll=%0b lf=%0b",
                                     tbl_idx[t], m_cmd_row, m_cmd_stripe, m_cmd_last_line,
                                     m_cmd_last_frame, tbl_row[t], tbl_str[t], tbl_ll[t], tbl_lf[t]);
                        end
                    end
                end
                if (m_cmd_tready) begin
                    void'(exp_q.pop_front());
                    popped = 1'b1;
                end
            end
        end

        while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            s = st_q.pop_front();
            checks++;
            if (s.cyc < cyc) begin
                errors++;
                $display("FAIL %s: status check missed (cycle %0d, now %0d)", s.name, s.cyc, cyc);
            end else begin
                matched = 1'b1;
                if ({m_cmd_tvalid, busy, frame_done, overrun} !== {s.valid, s.bsy, s.done, s.ovr}) begin
                    errors++;
                    $display("FAIL %s: got valid/busy/done/ovr=%b%b%b%b want %b%b%b%b", s.name,
                             m_cmd_tvalid, busy, frame_done, overrun, s.valid, s.bsy, s.done, s.ovr);
                end
                if (s.chk_cmd && (m_cmd_row !== RW'(s.row) || m_cmd_stripe !== SW'(s.stripe) ||
                    m_cmd_last_line !== s.ll || m_cmd_last_frame !== s.lf)) begin
                    errors++;
                    $display("FAIL %s_cmd: got row=%0d stripe=%0d ll=%0b lf=%0b want row=%0d stripe=%0d ll=%0b lf=%0b",
                             s.name, m_cmd_row, m_cmd_stripe, m_cmd_last_line, m_cmd_last_frame,
                             s.row, s.stripe, s.ll, s.lf);
                end
            end
        end

        if (!matched) begin
            checks++;
            if (frame_done || overrun) begin
                errors++;
                $display("FAIL spurious_pulse: got frame_done=%0b overrun=%0b want 0 0 at cycle %0d",
                         frame_done, overrun, cyc);
            end
        end

        if (exp_q.size() > 0 && !popped) stall_cnt++;
        else stall_cnt = 0;
        if (stall_cnt > 1000) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d commands still pending want 0", exp_q.size());
            exp_q.delete();
            stall_cnt = 0;
        end

        if (end_req && !end_done) begin
            end_done = 1'b1;
            checks++;
            if (exp_q.size() != 0 || st_q.size() != 0) begin
                errors++;
                $display("FAIL leftovers: got %0d commands %0d status pending want 0 0",
                         exp_q.size(), st_q.size());
            end
        end
    end

    initial begin
        s_axis_resetn = 1'b1;
        frame_start   = 1'b0;
        m_cmd_tready  = 1'b0;
        #1 s_axis_resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_status(1, "reset_state", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        s_axis_resetn = 1'b1;
        m_cmd_tready  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        expect_status(1, "idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Full frame at tready=1; next frame_start lands on the final handshake.
        start_frame();
        repeat (2703) @(posedge clk);
        #1;
        frame_start = 1'b1;
        push_frame();
        expect_status(1, "last_hs", 1, 1, 0, 0, 1, 103, 25, 1, 1);
        expect_status(2, "restart_on_last", 1, 1, 1, 0, 1, 48, 12, 0, 0);
        @(posedge clk); #1;
        frame_start = 1'b0;

        // Second frame under random backpressure.
        run_until_empty(1'b1);
        expect_status(1, "frame_end_bp", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        m_cmd_tready = 1'b1;
        @(posedge clk); #1;

        // Abort on the 100th handshake.
        start_frame();
        repeat (99) @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        exp_q.delete();
        push_frame();
        expect_status(1, "abort", 1, 1, 0, 1, 1, 48, 12, 0, 0);

        // Asynchronous reset mid-frame.
        repeat (50) @(posedge clk);
        #2;
        s_axis_resetn = 1'b0;
        exp_q.delete();
        expect_status(1, "async_reset", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        s_axis_resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        expect_status(1, "no_cmd_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Recovery frame.
        start_frame();
        run_until_empty(1'b0);
        expect_status(1, "frame_end", 0, 0, 1, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        end_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
